// File: rtl/tensor_job_arbiter.sv
// Round-robin job arbiter that sequences one requester's tensor job into per-element engine ops.
// Optional performance counters are enabled by defining TENSOR_ARB_PERF_EN.
module tensor_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int LEN_W   = 7,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base_a,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base_b,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base_r,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [ADDR_W-1:0]         op_addr_a,
  output logic [ADDR_W-1:0]         op_addr_b,
  output logic [ADDR_W-1:0]         op_addr_r,
  output logic                      op_last,
  input  logic                      op_done,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy
`ifdef TENSOR_ARB_PERF_EN
  ,
  output logic [31:0]               perf_busy_cyc,
  output logic [31:0]               perf_stall_cyc,
  output logic [15:0]               perf_jobs
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d, owner_q, owner_d;
  logic [LEN_W-1:0]    len_q, len_d, idx_q, idx_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, base_r_q, base_r_d;
  logic [OW-1:0]       out_q, out_d;

  logic                found;
  logic [IW-1:0]       win;
  logic [LEN_W-1:0]    sel_len;
  logic [ADDR_W-1:0]   sel_a, sel_b, sel_r;
  logic                accept, retire;

  // Winner is the first valid requester at or after the round-robin pointer.
  always_comb begin : arb
    int c;
    logic [IW-1:0] cand;
    found = 1'b0;
    win   = '0;
    c     = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c    = (int'(rr_q) + k) % NUM_REQ;
      cand = c[IW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_len   = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_r     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) begin
        sel_len = req_len[i*LEN_W +: LEN_W];
        sel_a   = req_base_a[i*ADDR_W +: ADDR_W];
        sel_b   = req_base_b[i*ADDR_W +: ADDR_W];
        sel_r   = req_base_r[i*ADDR_W +: ADDR_W];
      end
      req_ready[i] = (state_q == IDLE) && found && (win == IW'(i));
    end
  end

  assign op_valid  = (state_q == ISSUE) && (out_q < OW'(MAX_OUT));
  assign op_last   = (state_q == ISSUE) && (idx_q == len_q - LEN_W'(1));
  assign op_addr_a = base_a_q + ADDR_W'(idx_q);
  assign op_addr_b = base_b_q + ADDR_W'(idx_q);
  assign op_addr_r = base_r_q + ADDR_W'(idx_q);
  assign busy      = (state_q != IDLE);

  // A completion with nothing outstanding is stray and must not underflow the counter.
  assign accept = op_valid && op_ready;
  assign retire = op_done && (out_q != '0);
  assign out_d  = out_q + OW'(accept) - OW'(retire);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    len_d    = len_q;
    idx_d    = idx_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_r_d = base_r_q;
    done     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d  = win;
          len_d    = sel_len;
          base_a_d = sel_a;
          base_b_d = sel_b;
          base_r_d = sel_r;
          idx_d    = '0;
          state_d  = (sel_len != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (accept) begin
          idx_d = idx_q + LEN_W'(1);
          if (op_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_d == '0) state_d = DONE;
      end
      DONE: begin
        done[owner_q] = 1'b1;
        rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_r_q <= base_r_d;
      out_q    <= out_d;
    end
  end

`ifdef TENSOR_ARB_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;
  logic [15:0] perf_jobs_q;
  logic        stall;

  assign stall = (state_q == ISSUE) && ((op_valid && !op_ready) || (out_q == OW'(MAX_OUT)));

  // All counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
      perf_jobs_q  <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if ((done != '0) && (perf_jobs_q != '1)) perf_jobs_q <= perf_jobs_q + 16'd1;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
  assign perf_jobs      = perf_jobs_q;
`endif

endmodule

// File: tb/tb_tensor_job_arbiter.sv
// Randomized bench for tensor_job_arbiter, checked against a job-level behavioural model
// (requester pool, in-order engine with completion delays, per-job op counters).
module tb_tensor_job_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int LW = 7;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*LW-1:0]   req_len;
  logic [N*AW-1:0]   req_base_a, req_base_b, req_base_r;
  logic              op_valid, op_ready, op_last, op_done;
  logic [AW-1:0]     op_addr_a, op_addr_b, op_addr_r;
  logic [N-1:0]      done;
  logic              busy;
`ifdef TENSOR_ARB_PERF_EN
  logic [31:0]       perf_busy_cyc, perf_stall_cyc;
  logic [15:0]       perf_jobs;
`endif

  tensor_job_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_base_a(req_base_a), .req_base_b(req_base_b), .req_base_r(req_base_r),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_addr_a(op_addr_a), .op_addr_b(op_addr_b), .op_addr_r(op_addr_r),
    .op_last(op_last), .op_done(op_done), .done(done), .busy(busy)
`ifdef TENSOR_ARB_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc), .perf_jobs(perf_jobs)
`endif
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Requester pool: a pending job stays put until it is granted.
  bit pend [N];
  int pLen [N];
  int pA [N];
  int pB [N];
  int pR [N];

  // Job-level reference model.
  bit mIdle, mDonePending;
  int mRr, mOwner, mLen, mA, mB, mR, mIssued, mOut;

  // Engine: cycle numbers at which completions are due, in acceptance order.
  int doneQ [$];
  int lastDoneT;
  int cyc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel();
    mIdle = 1'b1; mDonePending = 1'b0;
    mRr = 0; mOwner = 0; mLen = 0; mA = 0; mB = 0; mR = 0; mIssued = 0; mOut = 0;
    doneQ.delete();
    lastDoneT = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_valid"}, 32'(op_valid), 32'd0);
    checkOutput({tag, "_last"},  32'(op_last), 32'd0);
    checkOutput({tag, "_done"},  32'(done), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_addr"},  32'({op_addr_a, op_addr_b, op_addr_r}), 32'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, check just after, advance the model.
  task automatic applyStimulus(input int readyPct, input int dMin, input int dMax,
                               input int newPct, input int dropPct);
    bit anyV, expValid, acc, ret;
    int w, c, t;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && newPct > 0 && $urandom_range(0, 99) < newPct) begin
        pend[i] = 1'b1;
        pLen[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
        pA[i] = $urandom_range(0, 63);
        pB[i] = $urandom_range(0, 63);
        pR[i] = $urandom_range(0, 63);
      end
      req_valid[i] = pend[i] && ($urandom_range(0, 99) >= dropPct);
      req_len[i*LW +: LW]    = LW'(pLen[i]);
      req_base_a[i*AW +: AW] = AW'(pA[i]);
      req_base_b[i*AW +: AW] = AW'(pB[i]);
      req_base_r[i*AW +: AW] = AW'(pR[i]);
    end
    op_ready = ($urandom_range(0, 99) < readyPct);
    op_done  = 1'b0;
    if (doneQ.size() > 0 && doneQ[0] <= cyc) begin
      op_done = 1'b1;
      void'(doneQ.pop_front());
    end else if (doneQ.size() == 0 && mOut == 0 && $urandom_range(0, 15) == 0) begin
      op_done = 1'b1;
    end
    #1;
    anyV = 1'b0; w = 0;
    for (int k = 0; k < N; k++) begin
      c = (mRr + k) % N;
      if (!anyV && req_valid[c]) begin anyV = 1'b1; w = c; end
    end
    expValid = !mIdle && !mDonePending && (mIssued < mLen) && (mOut < MO);
    checkOutput("busy", 32'(busy), 32'(!mIdle));
    checkOutput("req_ready", 32'(req_ready), (mIdle && anyV) ? (32'd1 << w) : 32'd0);
    checkOutput("done", 32'(done), (!mIdle && mDonePending) ? (32'd1 << mOwner) : 32'd0);
    checkOutput("op_valid", 32'(op_valid), 32'(expValid));
    if (expValid) begin
      checkOutput("addr_a", 32'(op_addr_a), 32'((mA + mIssued) % 64));
      checkOutput("addr_b", 32'(op_addr_b), 32'((mB + mIssued) % 64));
      checkOutput("addr_r", 32'(op_addr_r), 32'((mR + mIssued) % 64));
      checkOutput("op_last", 32'(op_last), 32'(mIssued == mLen - 1));
    end
    if (mIdle) begin
      if (anyV) begin
        mIdle = 1'b0; mOwner = w; mLen = pLen[w];
        mA = pA[w]; mB = pB[w]; mR = pR[w]; mIssued = 0;
        pend[w] = 1'b0;
        mDonePending = (mLen == 0);
      end
    end else if (mDonePending) begin
      mDonePending = 1'b0; mIdle = 1'b1; mRr = (mOwner + 1) % N;
    end else begin
      acc = expValid && op_ready;
      ret = op_done && (mOut > 0);
      mOut = mOut + int'(acc) - int'(ret);
      if (acc) begin
        mIssued++;
        t = cyc + $urandom_range(dMin, dMax);
        if (t <= lastDoneT) t = lastDoneT + 1;
        lastDoneT = t;
        doneQ.push_back(t);
      end
      if (mIssued == mLen && mOut == 0) mDonePending = 1'b1;
    end
    cyc++;
  endtask

  // Pull reset asynchronously while a job is part-way through issuing.
  task automatic resetMidJob();
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      applyStimulus(100, 8, 12, 40, 10);
      if (!mIdle && !mDonePending && mIssued >= 2 && mIssued < mLen) hit = 1'b1;
    end
    checkOutput("rst_window_found", 32'(hit), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("rst_pre_busy", 32'(busy), 32'd1);
    req_valid = '0;
    op_done   = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_len = '0;
    req_base_a = '0; req_base_b = '0; req_base_r = '0;
    op_ready = 1'b0; op_done = 1'b0;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pLen[i] = 0; pA[i] = 0; pB[i] = 0; pR[i] = 0;
    end
    resetModel();
    #3;
    checkResetOutputs("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed opening: a length-4 job on req0 plus two length-2 jobs queued behind it.
    pend[0] = 1'b1; pLen[0] = 4; pA[0] = 0;  pB[0] = 16; pR[0] = 32;
    pend[1] = 1'b1; pLen[1] = 2; pA[1] = 5;  pB[1] = 6;  pR[1] = 7;
    pend[2] = 1'b1; pLen[2] = 2; pA[2] = 62; pB[2] = 63; pR[2] = 1;
    repeat (40) applyStimulus(100, 2, 2, 0, 0);

    // Zero-length job, then a wrapping job.
    pend[3] = 1'b1; pLen[3] = 0; pA[3] = 0;  pB[3] = 0;  pR[3] = 0;
    repeat (6) applyStimulus(100, 1, 1, 0, 0);
    pend[0] = 1'b1; pLen[0] = 3; pA[0] = 62; pB[0] = 10; pR[0] = 20;
    repeat (20) applyStimulus(100, 1, 1, 0, 0);

    // Random traffic: mixed readiness, then slow completions to saturate the outstanding limit,
    // then heavy backpressure.
    repeat (1200) applyStimulus(70, 1, 4, 20, 12);
    repeat (800)  applyStimulus(100, 6, 12, 30, 12);
    repeat (800)  applyStimulus(30, 1, 3, 30, 12);

    resetMidJob();
    repeat (600) applyStimulus(70, 1, 6, 25, 10);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
